// File: rtl/instmem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instmem_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   loader_state_t  : loader FSM state encoding
//   HDR_BYTES       : number of bytes in the big-endian word-count header
//   BYTES_PER_WORD  : bytes per instruction word for a given word width
// -----------------------------------------------------------------------------
package instmem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CHK   = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } loader_state_t;

   localparam int unsigned HDR_BYTES = 32'd2;

   // Instruction words are always a whole number of bytes.
   function automatic int unsigned BYTES_PER_WORD(input int unsigned inst_w);
      return inst_w / 32'd8;
   endfunction

endpackage

// File: rtl/instmem_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
// Shift register plus byte counter that packs an MSB-first byte stream into a
// word. The same instance assembles the header, every instruction word and
// the optional checksum trailer; the caller selects the length per field.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous clear of the counter and the shift register
//   shift_en   : a byte is being accepted this cycle
//   byte_in    : byte to shift into the least-significant end
//   num_bytes  : bytes that make up the current field
//   word       : registered shift-register contents
//   word_full  : the byte accepted this cycle completes the field; the caller
//                combines it with byte_in to see the complete value one edge
//                early, so no cycle is lost between fields
// -----------------------------------------------------------------------------
module byte_assembler #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         shift_en,
   input  logic [7:0]   byte_in,
   input  logic [7:0]   num_bytes,
   output logic [W-1:0] word,
   output logic         word_full
);

   logic [7:0]   count_r;
   logic [W-1:0] word_r;

   assign word      = word_r;
   assign word_full = shift_en && (count_r == (num_bytes - 8'd1));

   // Shift register and byte counter; the counter wraps to zero as each field
   // completes so the next field starts without an explicit clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 8'd0;
         word_r  <= '0;
      end else if (clear) begin
         count_r <= 8'd0;
         word_r  <= '0;
      end else if (shift_en) begin
         word_r <= (word_r << 8) | W'(byte_in);
         if (word_full) begin
            count_r <= 8'd0;
         end else begin
            count_r <= count_r + 8'd1;
         end
      end else begin
         count_r <= count_r;
         word_r  <= word_r;
      end
   end

endmodule

// File: rtl/instmem_loader.sv
// -----------------------------------------------------------------------------
// instmem_loader
// Program loader placed in front of the pipelined MIPS CPU. A host byte stream
// (2-byte big-endian word count N, then N big-endian words) is accepted over a
// valid/ready handshake, each word is written to instruction memory from
// address 0, and enPC is raised once the whole image is stored.
//
// Optional feature: define INSTMEM_LOADER_CHECKSUM_EN to expect a trailing
// INST_W-bit checksum word equal to the mod-2**INST_W sum of all words. A
// mismatch ends in the error state with enPC low.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : one-cycle pulse beginning a load (IDLE/DONE/ERR)
//   byte_in, byte_valid      : stream data and its valid
//   byte_ready               : loader can accept a byte (HDR, DATA, CHK)
//   instmem_export_data      : word being written
//   instmem_export_address   : word address being written
//   instmem_export_MW        : one-cycle write strobe per word
//   instmem_export_MR        : read strobe, always 0
//   enPC                     : CPU run enable, high once the image is loaded
//   busy, done, error        : load in progress / complete / aborted
// -----------------------------------------------------------------------------
module instmem_loader
   import instmem_loader_pkg::*;
#(
   parameter int INST_W = 32,
   parameter int INST_A = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [INST_W-1:0] instmem_export_data,
   output logic [INST_A-1:0] instmem_export_address,
   output logic              instmem_export_MW,
   output logic              instmem_export_MR,
   output logic              enPC,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // The assembler must also hold the 16-bit header, even for narrow words.
   localparam int ASM_W = (INST_W > 16) ? INST_W : 16;

   localparam logic [7:0] WORD_BYTES   = 8'(BYTES_PER_WORD(INST_W));
   localparam logic [7:0] HEADER_BYTES = 8'(HDR_BYTES);

   localparam logic [2:0] S_IDLE  = IDLE;
   localparam logic [2:0] S_HDR   = HDR;
   localparam logic [2:0] S_DATA  = DATA;
   localparam logic [2:0] S_WRITE = WRITE;
   localparam logic [2:0] S_CHK   = CHK;
   localparam logic [2:0] S_DONE  = DONE;
   localparam logic [2:0] S_ERR   = ERR;

   // Where the FSM goes once the last word is written (or N is zero).
`ifdef INSTMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_END = S_CHK;
`else
   localparam logic [2:0] S_END = S_DONE;
`endif

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic              accept_s;
   logic              asm_clear_s;
   logic              asm_full_s;
   logic [7:0]        asm_num_s;
   logic [ASM_W-1:0]  asm_word_s;
   logic [ASM_W-1:0]  assembled_s;
   logic [15:0]       header_s;
   logic              more_s;
   logic              too_big_s;
   logic [INST_A:0]   index_r;
   logic [15:0]       words_r;
   logic              byte_ready_r;
   logic              busy_r;
   logic              done_r;
   logic              error_r;
   logic              enpc_r;
   logic              mw_r;
   logic [INST_A-1:0] address_r;
   logic [INST_W-1:0] data_r;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
   logic [INST_W-1:0] sum_r;
   logic              sum_ok_s;
`endif

   assign accept_s  = byte_valid && byte_ready_r;
   assign asm_num_s = (state_r == S_HDR) ? HEADER_BYTES : WORD_BYTES;

   // Value of the field including the byte accepted this cycle.
   assign assembled_s = (asm_word_s << 8) | ASM_W'(byte_in);
   assign header_s    = assembled_s[15:0];

   // index_r holds the index of the word in WRITE; more words follow if the
   // next index is still below N. Compared at 32 bits so N up to 65535 is safe.
   assign more_s    = (32'(index_r) + 32'd1) < {16'd0, words_r};
   assign too_big_s = {16'd0, header_s} > (32'd1 << INST_A);

`ifdef INSTMEM_LOADER_CHECKSUM_EN
   assign sum_ok_s = (assembled_s[INST_W-1:0] == sum_r);
`endif

   byte_assembler #(
      .W (ASM_W)
   ) u_byte_assembler (
      .clk       (clk),
      .rst       (rst),
      .clear     (asm_clear_s),
      .shift_en  (accept_s),
      .byte_in   (byte_in),
      .num_bytes (asm_num_s),
      .word      (asm_word_s),
      .word_full (asm_full_s)
   );

   // Next-state logic; a start pulse is honoured only in IDLE, DONE and ERR.
   always_comb begin
      state_nxt_s = state_r;
      asm_clear_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_HDR;
               asm_clear_s = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_HDR: begin
            if (asm_full_s) begin
               if (header_s == 16'd0) begin
                  state_nxt_s = S_END;
               end else if (too_big_s) begin
                  state_nxt_s = S_ERR;
               end else begin
                  state_nxt_s = S_DATA;
               end
            end else begin
               state_nxt_s = S_HDR;
            end
         end
         S_DATA: begin
            if (asm_full_s) begin
               state_nxt_s = S_WRITE;
            end else begin
               state_nxt_s = S_DATA;
            end
         end
         S_WRITE: begin
            if (more_s) begin
               state_nxt_s = S_DATA;
            end else begin
               state_nxt_s = S_END;
            end
         end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (asm_full_s) begin
               if (sum_ok_s) begin
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_ERR;
               end
            end else begin
               state_nxt_s = S_CHK;
            end
         end
`endif
         S_DONE, S_ERR: begin
            if (start) begin
               state_nxt_s = S_HDR;
               asm_clear_s = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Status outputs registered from the next state so they change together
   // with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_ready_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         enpc_r       <= 1'b0;
         error_r      <= 1'b0;
         mw_r         <= 1'b0;
      end else begin
         byte_ready_r <= (state_nxt_s == S_HDR) || (state_nxt_s == S_DATA) ||
                         (state_nxt_s == S_CHK);
         busy_r       <= (state_nxt_s == S_HDR) || (state_nxt_s == S_DATA) ||
                         (state_nxt_s == S_WRITE) || (state_nxt_s == S_CHK);
         done_r       <= (state_nxt_s == S_DONE);
         enpc_r       <= (state_nxt_s == S_DONE);
         error_r      <= (state_nxt_s == S_ERR);
         mw_r         <= (state_nxt_s == S_WRITE);
      end
   end

   // Write port: captured as the last byte of a word arrives so address and
   // data are valid for the whole WRITE cycle, then held until the next word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address_r <= '0;
         data_r    <= '0;
      end else if ((state_r == S_DATA) && (state_nxt_s == S_WRITE)) begin
         address_r <= index_r[INST_A-1:0];
         data_r    <= assembled_s[INST_W-1:0];
      end else begin
         address_r <= address_r;
         data_r    <= data_r;
      end
   end

   // Word index and the word count taken from the header.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index_r <= '0;
         words_r <= 16'd0;
      end else begin
         if (asm_clear_s) begin
            index_r <= '0;
         end else if (state_r == S_WRITE) begin
            index_r <= index_r + {{INST_A{1'b0}}, 1'b1};
         end else begin
            index_r <= index_r;
         end
         if ((state_r == S_HDR) && asm_full_s) begin
            words_r <= header_s;
         end else begin
            words_r <= words_r;
         end
      end
   end

`ifdef INSTMEM_LOADER_CHECKSUM_EN
   // Running sum of every written word, wrapping at INST_W bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r <= '0;
      end else if (asm_clear_s) begin
         sum_r <= '0;
      end else if (state_r == S_WRITE) begin
         sum_r <= sum_r + data_r;
      end else begin
         sum_r <= sum_r;
      end
   end
`endif

   assign byte_ready             = byte_ready_r;
   assign busy                   = busy_r;
   assign done                   = done_r;
   assign error                  = error_r;
   assign enPC                   = enpc_r;
   assign instmem_export_MW      = mw_r;
   assign instmem_export_MR      = 1'b0;
   assign instmem_export_address = address_r;
   assign instmem_export_data    = data_r;

endmodule

// File: tb/tb_instmem_loader.sv
// -----------------------------------------------------------------------------
// tb_instmem_loader
// Directed bench for instmem_loader (INST_W=32, INST_A=8). Expected writes are
// queued from the image being streamed (word i lands at address i); a compare
// process checks every write strobe against that queue and writes a sink
// memory. Stimulus checks status outputs at hand-computed points.
// Optional build: INSTMEM_LOADER_CHECKSUM_EN (trailer word appended).
// -----------------------------------------------------------------------------
module tb_instmem_loader;

   localparam int INST_W = 32;
   localparam int INST_A = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [INST_W-1:0] instmem_export_data;
   logic [INST_A-1:0] instmem_export_address;
   logic              instmem_export_MW;
   logic              instmem_export_MR;
   logic              enPC;
   logic              busy;
   logic              done;
   logic              error;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cyc = 0;
   int first_mw_cyc = -1;
   int mw_count = 0;
   int mw0 = 0;
   int exp_idx = 0;

   logic [INST_A-1:0] exp_addr_q[$];
   logic [INST_W-1:0] exp_data_q[$];
   logic [INST_W-1:0] sink_mem [0:255];
   logic [INST_W-1:0] words_tbl [0:7];

   instmem_loader #(
      .INST_W (INST_W),
      .INST_A (INST_A)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .start                  (start),
      .byte_in                (byte_in),
      .byte_valid             (byte_valid),
      .byte_ready             (byte_ready),
      .instmem_export_data    (instmem_export_data),
      .instmem_export_address (instmem_export_address),
      .instmem_export_MW      (instmem_export_MW),
      .instmem_export_MR      (instmem_export_MR),
      .enPC                   (enPC),
      .busy                   (busy),
      .done                   (done),
      .error                  (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle compare against the expected-write queue and the status rules.
   always @(negedge clk) begin
      if (!rst) begin
         chk("mr_tied_low", instmem_export_MR, 1'b0);
         chk("enpc_with_done", enPC, done);
         chk("busy_excl_status", busy && (done || error), 1'b0);
         if (instmem_export_MW) begin
            chk("ready_low_in_write", byte_ready, 1'b0);
            mw_count++;
            if (first_mw_cyc < 0) first_mw_cyc = cyc;
            if (exp_addr_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_mw: actual strobe addr=%0d data=0x%0h required no strobe",
                        instmem_export_address, instmem_export_data);
            end else begin
               chk("mw_addr", instmem_export_address, exp_addr_q[0]);
               chk("mw_data", instmem_export_data, exp_data_q[0]);
               void'(exp_addr_q.pop_front());
               void'(exp_data_q.pop_front());
            end
            sink_mem[instmem_export_address] = instmem_export_data;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_in = b;
      byte_valid = 1'b1;
      waited = 0;
      while (!byte_ready && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!byte_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_handshake_timeout: actual ready=0 required ready=1 within 64 cycles");
      end else begin
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31-8*i -: 8], int'($urandom_range(0, maxgap)));
      end
   endtask

   task automatic expect_word(input logic [31:0] w);
      logic [31:0] idx;
      idx = exp_idx;
      exp_addr_q.push_back(idx[INST_A-1:0]);
      exp_data_q.push_back(w);
      exp_idx++;
   endtask

   task automatic send_header(input int n);
      logic [15:0] h;
      h = n[15:0];
      send_byte(h[15:8], 0);
      send_byte(h[7:0], 0);
   endtask

   task automatic run_load(input int n, input int maxgap);
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      logic [31:0] sum;
      sum = 32'd0;
`endif
      send_header(n);
      for (int i = 0; i < n; i++) begin
         expect_word(words_tbl[i]);
         send_word(words_tbl[i], maxgap);
`ifdef INSTMEM_LOADER_CHECKSUM_EN
         sum = sum + words_tbl[i];
`endif
      end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      send_word(sum, maxgap);
`endif
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_cyc = cyc;
      first_mw_cyc = -1;
      exp_idx = 0;
   endtask

   // Called right after the final stream byte was accepted.
   task automatic wait_done(input string tag);
`ifndef INSTMEM_LOADER_CHECKSUM_EN
      chk({tag, "_last_write"}, instmem_export_MW, 1'b1);
      chk({tag, "_not_done_yet"}, done, 1'b0);
      @(negedge clk);
`endif
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_enpc"}, enPC, 1'b1);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_ready"}, byte_ready, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, byte_ready, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_enpc"}, enPC, 1'b0);
      chk({tag, "_mw"}, instmem_export_MW, 1'b0);
      chk({tag, "_mr"}, instmem_export_MR, 1'b0);
      chk({tag, "_addr"}, instmem_export_address, 8'd0);
      chk({tag, "_data"}, instmem_export_data, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=simulation still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      byte_valid = 1'b0;
      byte_in = 8'd0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("idle");

      // 1: three-word image, back-to-back bytes.
      words_tbl[0] = 32'h20080005;
      words_tbl[1] = 32'h20090007;
      words_tbl[2] = 32'h01095020;
      mw0 = mw_count;
      pulse_start();
      chk("t1_busy", busy, 1'b1);
      chk("t1_ready", byte_ready, 1'b1);
      run_load(3, 0);
      wait_done("t1");
      // Edge sampling start, 2 header edges, 4 data edges: strobe on the 7th.
      chk("t1_first_strobe_latency", first_mw_cyc - start_cyc, 6);
      chk("t1_strobes", mw_count - mw0, 3);
      chk("t1_mem0", sink_mem[0], 32'h20080005);
      chk("t1_mem1", sink_mem[1], 32'h20090007);
      chk("t1_mem2", sink_mem[2], 32'h01095020);
      repeat (3) @(negedge clk);
      chk("t1_done_held", done, 1'b1);
      chk("t1_enpc_held", enPC, 1'b1);

      // 2: empty image.
      mw0 = mw_count;
      pulse_start();
      chk("t2_done_cleared", done, 1'b0);
      chk("t2_enpc_cleared", enPC, 1'b0);
      chk("t2_busy", busy, 1'b1);
      send_header(0);
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      send_word(32'd0, 0);
`endif
      chk("t2_done", done, 1'b1);
      chk("t2_enpc", enPC, 1'b1);
      repeat (4) @(negedge clk);
      chk("t2_no_strobe", mw_count - mw0, 0);

      // 3: oversize header, then recovery.
      pulse_start();
      send_header(257);
      chk("t3_error", error, 1'b1);
      chk("t3_enpc", enPC, 1'b0);
      chk("t3_done", done, 1'b0);
      chk("t3_busy", busy, 1'b0);
      chk("t3_ready", byte_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk("t3_error_held", error, 1'b1);
      pulse_start();
      chk("t3_error_cleared", error, 1'b0);
      chk("t3_busy_again", busy, 1'b1);
      words_tbl[0] = 32'hDEADBEEF;
      words_tbl[1] = 32'h00C0FFEE;
      run_load(2, 0);
      wait_done("t3");
      chk("t3_mem1", sink_mem[1], 32'h00C0FFEE);

      // 4: two words with random valid gaps.
      words_tbl[0] = 32'h8C020004;
      words_tbl[1] = 32'hAC030008;
      mw0 = mw_count;
      pulse_start();
      run_load(2, 3);
      wait_done("t4");
      chk("t4_strobes", mw_count - mw0, 2);
      chk("t4_mem0", sink_mem[0], 32'h8C020004);
      chk("t4_mem1", sink_mem[1], 32'hAC030008);

      // 5: reset after two of four words, then a clean reload.
      words_tbl[0] = 32'h11111111;
      words_tbl[1] = 32'h22222222;
      pulse_start();
      send_header(4);
      for (int i = 0; i < 2; i++) begin
         expect_word(words_tbl[i]);
         send_word(words_tbl[i], 0);
      end
      @(negedge clk);
      chk("t5_pre_addr", instmem_export_address, 8'd1);
      rst = 1'b1;
      #1;
      chk_all_zero("t5_rst");
      exp_addr_q.delete();
      exp_data_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      words_tbl[0] = 32'hAAAA0000;
      words_tbl[1] = 32'hAAAA0001;
      words_tbl[2] = 32'hAAAA0002;
      words_tbl[3] = 32'hAAAA0003;
      mw0 = mw_count;
      pulse_start();
      run_load(4, 1);
      wait_done("t5");
      chk("t5_strobes", mw_count - mw0, 4);
      chk("t5_mem0", sink_mem[0], 32'hAAAA0000);
      chk("t5_mem3", sink_mem[3], 32'hAAAA0003);

`ifdef INSTMEM_LOADER_CHECKSUM_EN
      // 6: checksum trailer, 0x00000001 + 0xFFFFFFFF wraps to 0.
      pulse_start();
      send_header(2);
      expect_word(32'h00000001);
      send_word(32'h00000001, 0);
      expect_word(32'hFFFFFFFF);
      send_word(32'hFFFFFFFF, 0);
      chk("t6_in_chk_ready", byte_ready, 1'b0);
      send_word(32'h00000000, 0);
      chk("t6_done", done, 1'b1);
      chk("t6_enpc", enPC, 1'b1);
      chk("t6_error", error, 1'b0);

      pulse_start();
      send_header(2);
      expect_word(32'h00000001);
      send_word(32'h00000001, 0);
      expect_word(32'hFFFFFFFF);
      send_word(32'hFFFFFFFF, 0);
      send_word(32'h00000001, 0);
      chk("t6_bad_error", error, 1'b1);
      chk("t6_bad_enpc", enPC, 1'b0);
      chk("t6_bad_done", done, 1'b0);
`endif

      repeat (3) @(negedge clk);
      chk("pending_writes", exp_addr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
